// File: rtl/sva_pkg.sv
// Shared types for the goto-repetition tracker: FSM states, slot record,
// per-thread result codes and the slot update rule used by scan and spawn.
package sva_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, SPAWN} ctrl_fsm_t;

    typedef enum logic [1:0] {NONE, SUCC, FAIL} res_t;

    // Slot fields are carried at a fixed width so one struct serves every
    // parameterisation; HITS and MAX_LEN must stay below 2**SLOT_W.
    localparam int SLOT_W = 8;

    typedef logic [SLOT_W-1:0] slot_cnt_t;

    typedef struct packed {
        logic      active;
        slot_cnt_t hits;
        slot_cnt_t age;
    } slot_t;

    typedef struct packed {
        res_t  res;
        slot_t slot;
    } slot_upd_t;

    function automatic slot_upd_t slot_update(
        input slot_t     s,
        input logic      b,
        input slot_cnt_t hits_tgt,
        input slot_cnt_t max_len
    );
        slot_upd_t u;
        slot_cnt_t h;
        slot_cnt_t a;
        h = s.hits + slot_cnt_t'(b);
        a = s.age + slot_cnt_t'(1);
        u.res  = NONE;
        u.slot = '{active: 1'b1, hits: h, age: a};
        // Success wins over timeout when both land on the same sample.
        if (h == hits_tgt) begin
            u.res  = SUCC;
            u.slot = '0;
        end else if (a >= max_len) begin
            u.res  = FAIL;
            u.slot = '0;
        end
        return u;
    endfunction

endpackage

// File: rtl/sva_goto_tracker_if.sv
// Control/status bundle of the tracker: sample strobes in, pulses and
// counters out. The bench drives the master side.
interface sva_goto_tracker_if #(
    parameter int NUM_THREADS = 4,
    parameter int CNT_WIDTH   = 16
);
    localparam int AC_W = $clog2(NUM_THREADS + 1);

    logic                 clr;
    logic                 sample_en;
    logic                 start;
    logic                 b;
    logic                 busy;
    logic                 succ;
    logic                 fail;
    logic                 overflow;
    logic                 overrun;
    logic [AC_W-1:0]      active_cnt;
    logic [CNT_WIDTH-1:0] succ_cnt;
    logic [CNT_WIDTH-1:0] fail_cnt;

    modport master (
        output clr, sample_en, start, b,
        input  busy, succ, fail, overflow, overrun, active_cnt, succ_cnt, fail_cnt
    );

    modport slave (
        input  clr, sample_en, start, b,
        output busy, succ, fail, overflow, overrun, active_cnt, succ_cnt, fail_cnt
    );
endinterface

// File: rtl/sva_slot_alloc.sv
// Lowest-index free slot finder over the active vector.
module sva_slot_alloc #(
    parameter int NUM_THREADS = 4,
    parameter int IDX_W       = 2
) (
    input  logic [NUM_THREADS-1:0] active_i,
    output logic [IDX_W-1:0]       free_idx_o,
    output logic                   found_o
);
    // Walking downward leaves the lowest free index as the final winner.
    always_comb begin
        free_idx_o = '0;
        found_o    = 1'b0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (!active_i[i]) begin
                free_idx_o = IDX_W'(i);
                found_o    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sva_goto_tracker.sv
// Multi-thread checker for `start ##0 b[->HITS]` bounded to MAX_LEN samples;
// each accepted sample is applied to the live slots one per clock, then spawns.
module sva_goto_tracker
    import sva_pkg::*;
#(
    parameter int NUM_THREADS = 4,
    parameter int HITS        = 2,
    parameter int MAX_LEN     = 8,
    parameter int CNT_WIDTH   = 16
) (
    input logic               sys_clk,
    input logic               sys_rst_n,
    sva_goto_tracker_if.slave bus
);
    localparam int IDX_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
    localparam int AC_W  = $clog2(NUM_THREADS + 1);

    localparam slot_cnt_t       HITS_V     = slot_cnt_t'(HITS);
    localparam slot_cnt_t       MAXLEN_V   = slot_cnt_t'(MAX_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_THREADS - 1);
    localparam slot_t           SPAWN_SEED = '{active: 1'b1, hits: '0, age: '0};

    ctrl_fsm_t            state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 b_s_q, start_s_q;
    slot_t                slots_q [NUM_THREADS];
    slot_t                slots_d [NUM_THREADS];
    logic [AC_W-1:0]      active_cnt_q;
    logic [CNT_WIDTH-1:0] succ_cnt_q, fail_cnt_q;

    logic [NUM_THREADS-1:0] active_vec;
    logic [IDX_W-1:0]       free_idx;
    logic                   found;
    slot_upd_t              upd;
    logic                   ovf;
    logic                   busy;
    logic                   succ_pulse, fail_pulse;

    function automatic logic [AC_W-1:0] popcount(input logic [NUM_THREADS-1:0] v);
        logic [AC_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_THREADS; i++) n = n + AC_W'(v[i]);
        return n;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_THREADS; i++) active_vec[i] = slots_q[i].active;
    end

    sva_slot_alloc #(
        .NUM_THREADS(NUM_THREADS),
        .IDX_W      (IDX_W)
    ) u_alloc (
        .active_i  (active_vec),
        .free_idx_o(free_idx),
        .found_o   (found)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else if (bus.clr) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (bus.sample_en) begin
                state_d = SCAN;
                idx_d   = '0;
            end
            SCAN: if (idx_q == LAST_IDX) state_d = SPAWN;
                  else                   idx_d   = idx_q + IDX_W'(1);
            SPAWN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Inactive slots still consume their scan cycle but produce no result.
    always_comb begin
        slots_d = slots_q;
        upd     = '0;
        ovf     = 1'b0;
        case (state_q)
            SCAN: if (slots_q[idx_q].active) begin
                upd            = slot_update(slots_q[idx_q], b_s_q, HITS_V, MAXLEN_V);
                slots_d[idx_q] = upd.slot;
            end
            SPAWN: if (start_s_q) begin
                upd = slot_update(SPAWN_SEED, b_s_q, HITS_V, MAXLEN_V);
                if (upd.res == NONE) begin
                    if (found) slots_d[free_idx] = upd.slot;
                    else       ovf               = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign succ_pulse = (upd.res == SUCC);
    assign fail_pulse = (upd.res == FAIL);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            slots_q      <= '{default: '0};
            b_s_q        <= 1'b0;
            start_s_q    <= 1'b0;
            active_cnt_q <= '0;
            succ_cnt_q   <= '0;
            fail_cnt_q   <= '0;
        end else if (bus.clr) begin
            slots_q      <= '{default: '0};
            b_s_q        <= 1'b0;
            start_s_q    <= 1'b0;
            active_cnt_q <= '0;
            succ_cnt_q   <= '0;
            fail_cnt_q   <= '0;
        end else begin
            slots_q      <= slots_d;
            active_cnt_q <= popcount(active_vec);
            if (state_q == IDLE && bus.sample_en) begin
                b_s_q     <= bus.b;
                start_s_q <= bus.start;
            end
            if (succ_pulse && succ_cnt_q != '1) succ_cnt_q <= succ_cnt_q + CNT_WIDTH'(1);
            if (fail_pulse && fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign bus.busy       = busy;
    assign bus.succ       = succ_pulse;
    assign bus.fail       = fail_pulse;
    assign bus.overflow   = ovf;
    assign bus.overrun    = bus.sample_en & busy;
    assign bus.active_cnt = active_cnt_q;
    assign bus.succ_cnt   = succ_cnt_q;
    assign bus.fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_sva_goto_tracker.sv
// Bench for sva_goto_tracker: a thread model predicts succ/fail/overflow
// pulses per cycle into a queue that a negedge monitor drains.
module tb_sva_goto_tracker;
    localparam int N  = 4;
    localparam int H  = 2;
    localparam int ML = 8;
    localparam int CW = 16;
    localparam logic [2:0] K_SUCC = 3'b001;
    localparam logic [2:0] K_FAIL = 3'b010;
    localparam logic [2:0] K_OVF  = 3'b100;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    sva_goto_tracker_if #(.NUM_THREADS(N), .CNT_WIDTH(CW)) if0 ();
    sva_goto_tracker_if #(.NUM_THREADS(N), .CNT_WIDTH(CW)) if1 ();

    sva_goto_tracker #(.NUM_THREADS(N), .HITS(H), .MAX_LEN(ML), .CNT_WIDTH(CW)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if0));
    sva_goto_tracker #(.NUM_THREADS(N), .HITS(1), .MAX_LEN(ML), .CNT_WIDTH(CW)) dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if1));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ovf0_seen = 0;
    int ovf1_seen = 0;

    typedef struct { int cyc; logic [2:0] kind; } ev_t;
    ev_t exp_q[$];

    bit m_act  [N];
    int m_hits [N];
    int m_age  [N];

    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic void push_ev(input int c, input logic [2:0] k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        exp_q.push_back(e);
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < N; k++) begin
            m_act[k] = 1'b0; m_hits[k] = 0; m_age[k] = 0;
        end
    endfunction

    // Expected events of a sample taken in cycle t: slot k reports in t+1+k,
    // the spawn decision in t+N+1.
    function automatic void model_sample(input int t, input logic bv, input logic sv);
        int h, a;
        bit placed;
        for (int k = 0; k < N; k++) begin
            if (m_act[k]) begin
                h = m_hits[k] + (bv ? 1 : 0);
                a = m_age[k] + 1;
                if (h == H)        begin push_ev(t + 1 + k, K_SUCC); m_act[k] = 1'b0; end
                else if (a >= ML)  begin push_ev(t + 1 + k, K_FAIL); m_act[k] = 1'b0; end
                else               begin m_hits[k] = h; m_age[k] = a; end
            end
        end
        if (sv) begin
            h = bv ? 1 : 0;
            if (h == H)        push_ev(t + N + 1, K_SUCC);
            else if (1 >= ML)  push_ev(t + N + 1, K_FAIL);
            else begin
                placed = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!placed && !m_act[k]) begin
                        m_act[k] = 1'b1; m_hits[k] = h; m_age[k] = 1; placed = 1'b1;
                    end
                end
                if (!placed) push_ev(t + N + 1, K_OVF);
            end
        end
    endfunction

    always @(negedge sys_clk) begin : monitor
        logic [2:0] obs, expc;
        ev_t e;
        obs  = {if0.overflow, if0.fail, if0.succ};
        expc = 3'b000;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            expc = e.kind;
        end
        if (obs != 3'b000 || expc != 3'b000) begin
            total++;
            if (obs !== expc) begin
                bad++;
                $display("FAIL pulse cyc=%0d got {ovf,fail,succ}=%b want=%b", cyc, obs, expc);
            end
        end
        if (if0.overflow) ovf0_seen++;
        if (if1.overflow) ovf1_seen++;
    end

    // Call at #1 after a posedge with dut idle; returns N+3 cycles later.
    task automatic send(input logic bv, input logic sv);
        model_sample(cyc, bv, sv);
        if0.b = bv; if0.start = sv; if0.sample_en = 1'b1;
        @(posedge sys_clk); #1;
        if0.sample_en = 1'b0; if0.b = 1'b0; if0.start = 1'b0;
        repeat (N + 2) @(posedge sys_clk);
        #1;
    endtask

    task automatic send1(input logic bv, input logic sv);
        if1.b = bv; if1.start = sv; if1.sample_en = 1'b1;
        @(posedge sys_clk); #1;
        if1.sample_en = 1'b0; if1.b = 1'b0; if1.start = 1'b0;
        repeat (N + 2) @(posedge sys_clk);
        #1;
    endtask

    task automatic do_clr();
        if0.clr = 1'b1;
        @(posedge sys_clk); #1;
        if0.clr = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        total++; if ({if0.busy, if0.succ, if0.fail, if0.overflow, if0.overrun} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=00000",
                {if0.busy, if0.succ, if0.fail, if0.overflow, if0.overrun}); end
        total++; if (if0.active_cnt !== 3'd0) begin
            bad++; $display("FAIL reset_active got=%0d want=0", if0.active_cnt); end
        total++; if (if0.succ_cnt !== 16'd0 || if0.fail_cnt !== 16'd0) begin
            bad++; $display("FAIL reset_cnts got=%0d/%0d want=0/0", if0.succ_cnt, if0.fail_cnt); end
        total++; if ({if1.busy, if1.succ, if1.active_cnt, if1.succ_cnt} !== '0) begin
            bad++; $display("FAIL reset_dut1 got busy=%b cnt=%0d want 0", if1.busy, if1.succ_cnt); end
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
    endtask

    task automatic test_success();
        do_clr();
        send(1'b0, 1'b1);
        total++; if (if0.active_cnt !== 3'd1) begin
            bad++; $display("FAIL succ_spawn_active got=%0d want=1", if0.active_cnt); end
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        total++; if (if0.succ_cnt !== 16'd1 || if0.fail_cnt !== 16'd0) begin
            bad++; $display("FAIL succ_cnts got=%0d/%0d want=1/0", if0.succ_cnt, if0.fail_cnt); end
        total++; if (if0.active_cnt !== 3'd0) begin
            bad++; $display("FAIL succ_active got=%0d want=0", if0.active_cnt); end
    endtask

    task automatic test_timeout();
        do_clr();
        send(1'b0, 1'b1);
        repeat (7) send(1'b0, 1'b0);
        total++; if (if0.fail_cnt !== 16'd1 || if0.succ_cnt !== 16'd0) begin
            bad++; $display("FAIL tmo_cnts got fail=%0d succ=%0d want=1/0", if0.fail_cnt, if0.succ_cnt); end
        total++; if (if0.active_cnt !== 3'd0) begin
            bad++; $display("FAIL tmo_active got=%0d want=0", if0.active_cnt); end
    endtask

    task automatic test_overflow();
        int exp_ac [5] = '{1, 2, 3, 4, 4};
        do_clr();
        ovf0_seen = 0;
        for (int i = 0; i < 5; i++) begin
            send(1'b0, 1'b1);
            total++; if (int'(if0.active_cnt) != exp_ac[i]) begin
                bad++; $display("FAIL ovf_active[%0d] got=%0d want=%0d", i, if0.active_cnt, exp_ac[i]); end
        end
        total++; if (ovf0_seen != 1) begin
            bad++; $display("FAIL ovf_once got=%0d want=1", ovf0_seen); end
        // Slot 0 times out on the eighth sample, and its spawn reuses it.
        repeat (3) send(1'b0, 1'b1);
        total++; if (ovf0_seen != 3 || if0.fail_cnt !== 16'd1) begin
            bad++; $display("FAIL ovf_reuse got ovf=%0d fail=%0d want=3/1", ovf0_seen, if0.fail_cnt); end
        total++; if (if0.active_cnt !== 3'd4) begin
            bad++; $display("FAIL ovf_reuse_active got=%0d want=4", if0.active_cnt); end
    endtask

    task automatic test_overrun();
        do_clr();
        send(1'b0, 1'b1);
        model_sample(cyc, 1'b0, 1'b0);
        if0.b = 1'b0; if0.start = 1'b0; if0.sample_en = 1'b1;
        @(negedge sys_clk);
        total++; if (if0.overrun !== 1'b0) begin
            bad++; $display("FAIL overrun_idle got=%b want=0", if0.overrun); end
        @(posedge sys_clk); #1;
        if0.sample_en = 1'b0;
        @(posedge sys_clk); #1;
        if0.b = 1'b1; if0.start = 1'b1; if0.sample_en = 1'b1;
        @(negedge sys_clk);
        total++; if (if0.overrun !== 1'b1) begin
            bad++; $display("FAIL overrun_busy got=%b want=1", if0.overrun); end
        @(posedge sys_clk); #1;
        if0.sample_en = 1'b0; if0.b = 1'b0; if0.start = 1'b0;
        repeat (N + 1) @(posedge sys_clk);
        #1;
        total++; if (if0.active_cnt !== 3'd1) begin
            bad++; $display("FAIL overrun_active got=%0d want=1", if0.active_cnt); end
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        total++; if (if0.succ_cnt !== 16'd1 || if0.active_cnt !== 3'd0) begin
            bad++; $display("FAIL overrun_after got succ=%0d act=%0d want=1/0", if0.succ_cnt, if0.active_cnt); end
    endtask

    task automatic test_hits1();
        if1.b = 1'b1; if1.start = 1'b1; if1.sample_en = 1'b1;
        @(posedge sys_clk); #1;
        if1.sample_en = 1'b0; if1.b = 1'b0; if1.start = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        total++; if (if1.succ !== 1'b0) begin
            bad++; $display("FAIL h1_early got=%b want=0", if1.succ); end
        @(negedge sys_clk);
        total++; if (if1.succ !== 1'b1) begin
            bad++; $display("FAIL h1_spawn_succ got=%b want=1", if1.succ); end
        repeat (2) @(posedge sys_clk);
        #1;
        total++; if (if1.active_cnt !== 3'd0 || if1.succ_cnt !== 16'd1) begin
            bad++; $display("FAIL h1_first got act=%0d succ=%0d want=0/1", if1.active_cnt, if1.succ_cnt); end
        repeat (5) send1(1'b1, 1'b1);
        total++; if (if1.succ_cnt !== 16'd6) begin
            bad++; $display("FAIL h1_count got=%0d want=6", if1.succ_cnt); end
        total++; if (ovf1_seen != 0 || if1.active_cnt !== 3'd0) begin
            bad++; $display("FAIL h1_no_ovf got ovf=%0d act=%0d want=0/0", ovf1_seen, if1.active_cnt); end
    endtask

    task automatic test_reset_mid();
        send(1'b0, 1'b1);
        send(1'b0, 1'b1);
        if0.b = 1'b0; if0.start = 1'b0; if0.sample_en = 1'b1;
        @(posedge sys_clk); #1;
        if0.sample_en = 1'b0;
        @(posedge sys_clk); #1;
        total++; if (if0.busy !== 1'b1 || if0.active_cnt !== 3'd2) begin
            bad++; $display("FAIL rstmid_pre got busy=%b act=%0d want=1/2", if0.busy, if0.active_cnt); end
        sys_rst_n = 1'b0;
        model_clear();
        #1;
        total++; if ({if0.busy, if0.succ, if0.fail, if0.overflow, if0.overrun} !== 5'b0) begin
            bad++; $display("FAIL rstmid_flags got=%b want=00000",
                {if0.busy, if0.succ, if0.fail, if0.overflow, if0.overrun}); end
        total++; if (if0.active_cnt !== 3'd0 || if0.succ_cnt !== 16'd0 || if0.fail_cnt !== 16'd0) begin
            bad++; $display("FAIL rstmid_cnts got act=%0d succ=%0d fail=%0d want 0", if0.active_cnt,
                if0.succ_cnt, if0.fail_cnt); end
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        total++; if (if0.busy !== 1'b0 || if0.active_cnt !== 3'd0) begin
            bad++; $display("FAIL rstmid_post got busy=%b act=%0d want=0/0", if0.busy, if0.active_cnt); end
    endtask

    task automatic test_clr_busy();
        send(1'b1, 1'b1);
        send(1'b1, 1'b0);
        send(1'b0, 1'b1);
        total++; if (if0.succ_cnt !== 16'd1 || if0.active_cnt !== 3'd1) begin
            bad++; $display("FAIL clr_pre got succ=%0d act=%0d want=1/1", if0.succ_cnt, if0.active_cnt); end
        if0.b = 1'b0; if0.start = 1'b0; if0.sample_en = 1'b1;
        @(posedge sys_clk); #1;
        if0.sample_en = 1'b0;
        @(posedge sys_clk); #1;
        if0.clr = 1'b1;
        @(posedge sys_clk); #1;
        if0.clr = 1'b0;
        model_clear();
        total++; if (if0.busy !== 1'b0 || if0.active_cnt !== 3'd0) begin
            bad++; $display("FAIL clr_state got busy=%b act=%0d want=0/0", if0.busy, if0.active_cnt); end
        total++; if (if0.succ_cnt !== 16'd0 || if0.fail_cnt !== 16'd0) begin
            bad++; $display("FAIL clr_cnts got=%0d/%0d want=0/0", if0.succ_cnt, if0.fail_cnt); end
        if0.clr = 1'b1; if0.sample_en = 1'b1; if0.start = 1'b1; if0.b = 1'b0;
        @(posedge sys_clk); #1;
        if0.clr = 1'b0; if0.sample_en = 1'b0; if0.start = 1'b0;
        total++; if (if0.busy !== 1'b0) begin
            bad++; $display("FAIL clr_sample_busy got=%b want=0", if0.busy); end
        repeat (N + 3) @(posedge sys_clk);
        #1;
        total++; if (if0.active_cnt !== 3'd0) begin
            bad++; $display("FAIL clr_sample_active got=%0d want=0", if0.active_cnt); end
    endtask

    initial begin
        if0.clr = 1'b0; if0.sample_en = 1'b0; if0.start = 1'b0; if0.b = 1'b0;
        if1.clr = 1'b0; if1.sample_en = 1'b0; if1.start = 1'b0; if1.b = 1'b0;
        model_clear();
        test_reset();
        test_success();
        test_timeout();
        test_overflow();
        test_overrun();
        test_hits1();
        test_reset_mid();
        test_clr_busy();
        repeat (2) @(posedge sys_clk);
        #1;
        total++; if (exp_q.size() != 0) begin
            bad++; $display("FAIL pending_events got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
